// File: rtl/regfile_bypass_sb.sv
// Register file with optional write-to-read bypass, per-register valid bits
// and a busy-bit scoreboard for decode-stage RAW hazard detection.
module regfile_bypass_sb #(
    parameter int AddrL  = 5,
    parameter int WL     = 32,
    parameter int NR     = 2,
    parameter int BYPASS = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                regwrite,
    input  logic [AddrL-1:0]    WriteReg,
    input  logic [WL-1:0]       WriteData,
    input  logic [NR*AddrL-1:0] ReadReg,
    output logic [NR*WL-1:0]    ReadData,
    output logic [NR-1:0]       ReadBusy,
    input  logic                issue_valid,
    input  logic [AddrL-1:0]    issue_dest,
    output logic [AddrL:0]      busy_cnt
);

    localparam int   Depth  = 2 ** AddrL;
    localparam logic Byp    = (BYPASS != 0);
    localparam logic [AddrL:0] CntOne = {{AddrL{1'b0}}, 1'b1};

    logic [WL-1:0]    rf [Depth];
    logic [Depth-1:0] valid;
    logic [Depth-1:0] busy;
    logic [AddrL:0]   busyCnt;
    logic             wrEn;
    logic             isEn;
    logic             setOne;
    logic             clrOne;
    logic [AddrL:0]   cntNext;

    assign wrEn = regwrite & (WriteReg != '0);
    assign isEn = issue_valid & (issue_dest != '0);

    // A same-register issue keeps the register busy, so the write clears nothing.
    always_comb begin
        setOne  = isEn & ~busy[issue_dest];
        clrOne  = wrEn & busy[WriteReg] & ~(isEn & (issue_dest == WriteReg));
        cntNext = busyCnt;
        if (setOne && !clrOne)
            cntNext = busyCnt + CntOne;
        else if (clrOne && !setOne)
            cntNext = busyCnt - CntOne;
    end

    always_ff @(posedge clk) begin
        if (!rst && wrEn)
            rf[WriteReg] <= WriteData;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid   <= '0;
            busy    <= '0;
            busyCnt <= '0;
        end else begin
            if (wrEn) begin
                valid[WriteReg] <= 1'b1;
                busy[WriteReg]  <= 1'b0;
            end
            if (isEn)
                busy[issue_dest] <= 1'b1;
            busyCnt <= cntNext;
        end
    end

    assign busy_cnt = busyCnt;

    for (genvar i = 0; i < NR; i++) begin : g_rd
        logic [AddrL-1:0] addr;
        logic             hit;
        logic             zero;

        assign addr = ReadReg[i*AddrL +: AddrL];
        assign hit  = Byp & regwrite & (WriteReg == addr);
        assign zero = rst | (addr == '0);

        assign ReadData[i*WL +: WL] = zero        ? '0 :
                                      hit         ? WriteData :
                                      !valid[addr] ? '0 : rf[addr];

        assign ReadBusy[i] = ~zero & busy[addr] & ~hit;
    end

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Bench for regfile_bypass_sb: directed vector table, reset sweep and
// randomized traffic against an array-based reference model.
module tb_regfile_bypass_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic        regwrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [9:0]  ReadReg;
    logic [63:0] ReadData;
    logic [1:0]  ReadBusy;
    logic        issue_valid;
    logic [4:0]  issue_dest;
    logic [5:0]  busy_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_bypass_sb #(.AddrL(5), .WL(32), .NR(2), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .regwrite(regwrite), .WriteReg(WriteReg),
        .WriteData(WriteData), .ReadReg(ReadReg), .ReadData(ReadData),
        .ReadBusy(ReadBusy), .issue_valid(issue_valid),
        .issue_dest(issue_dest), .busy_cnt(busy_cnt)
    );

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic        iv;
        logic [4:0]  id;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  eb;
        logic [5:0]  ec;
    } vec_t;

    vec_t tbl[18];

    // Reference model state
    logic [31:0] mRf [32];
    bit          mValid [32];
    bit          mBusy [32];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic we,
        input logic [4:0] wr, input logic [31:0] wd, input logic [4:0] r0,
        input logic [4:0] r1, input logic iv, input logic [4:0] id,
        input logic [31:0] e0, input logic [31:0] e1, input logic [1:0] eb,
        input logic [5:0] ec);
        vec_t v;
        v.rst = r; v.we = we; v.wr = wr; v.wd = wd; v.r0 = r0; v.r1 = r1;
        v.iv = iv; v.id = id; v.e0 = e0; v.e1 = e1; v.eb = eb; v.ec = ec;
        return v;
    endfunction

    task automatic drive(input logic r, input logic we, input logic [4:0] wr,
        input logic [31:0] wd, input logic [4:0] r0, input logic [4:0] r1,
        input logic iv, input logic [4:0] id);
        rst = r; regwrite = we; WriteReg = wr; WriteData = wd;
        ReadReg = {r1, r0}; issue_valid = iv; issue_dest = id;
    endtask

    function automatic logic [31:0] mRead(input logic [4:0] a);
        if (rst || a == 0) return 32'h0;
        if (regwrite && WriteReg == a) return WriteData;
        if (!mValid[a]) return 32'h0;
        return mRf[a];
    endfunction

    function automatic logic mBusyRd(input logic [4:0] a);
        if (rst || a == 0) return 1'b0;
        if (regwrite && WriteReg == a) return 1'b0;
        return mBusy[a];
    endfunction

    function automatic int mCount();
        int n = 0;
        for (int k = 0; k < 32; k++) n += mBusy[k] ? 1 : 0;
        return n;
    endfunction

    task automatic mEdge();
        if (rst) begin
            for (int k = 0; k < 32; k++) begin
                mValid[k] = 0;
                mBusy[k]  = 0;
            end
        end else begin
            if (regwrite && WriteReg != 0) begin
                mRf[WriteReg]    = WriteData;
                mValid[WriteReg] = 1;
                mBusy[WriteReg]  = 0;
            end
            if (issue_valid && issue_dest != 0)
                mBusy[issue_dest] = 1;
        end
    endtask

    initial begin
        tbl[0]  = mk(1,1,5,32'hAA,5,5,0,0, 0,0,2'b00,0);
        tbl[1]  = mk(0,1,5,32'hDEADBEEF,5,5,0,0, 32'hDEADBEEF,32'hDEADBEEF,2'b00,0);
        tbl[2]  = mk(0,0,0,0,5,0,0,0, 32'hDEADBEEF,0,2'b00,0);
        tbl[3]  = mk(0,1,0,32'h1234,0,0,1,0, 0,0,2'b00,0);
        tbl[4]  = mk(0,0,0,0,0,0,0,0, 0,0,2'b00,0);
        tbl[5]  = mk(0,0,0,0,7,1,1,7, 0,0,2'b00,1);
        tbl[6]  = mk(0,0,0,0,7,7,0,0, 0,0,2'b11,1);
        tbl[7]  = mk(0,1,7,9,7,5,0,0, 9,32'hDEADBEEF,2'b00,0);
        tbl[8]  = mk(0,0,0,0,7,7,0,0, 9,9,2'b00,0);
        tbl[9]  = mk(0,0,0,0,3,0,1,3, 0,0,2'b00,1);
        tbl[10] = mk(0,1,3,4,3,3,1,3, 4,4,2'b00,1);
        tbl[11] = mk(0,0,0,0,3,3,0,0, 4,4,2'b11,1);
        tbl[12] = mk(0,0,0,0,9,3,1,9, 0,4,2'b10,2);
        tbl[13] = mk(0,1,9,5,8,9,1,8, 0,5,2'b00,2);
        tbl[14] = mk(0,0,0,0,8,9,0,0, 0,5,2'b01,2);
        tbl[15] = mk(0,1,2,11,2,2,0,0, 11,11,2'b00,2);
        tbl[16] = mk(1,1,2,22,2,3,0,0, 0,0,2'b00,0);
        tbl[17] = mk(0,0,0,0,2,3,0,0, 0,0,2'b00,0);

        drive(1,0,0,0,0,0,0,0);
        repeat (2) @(posedge clk);
        #1;
        drive(0,0,0,0,0,0,0,0);
        #2;
        chk("reset_cnt", 64'(busy_cnt), 64'd0);

        for (int r = 1; r < 32; r++) begin
            ReadReg = {5'(r), 5'(r)};
            #1;
            chk($sformatf("rst_rd r%0d", r), ReadData, 64'd0);
            chk($sformatf("rst_busy r%0d", r), 64'(ReadBusy), 64'd0);
        end
        @(posedge clk);
        #1;

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].rst, tbl[i].we, tbl[i].wr, tbl[i].wd,
                  tbl[i].r0, tbl[i].r1, tbl[i].iv, tbl[i].id);
            #2;
            chk($sformatf("vec%0d rd0", i), 64'(ReadData[31:0]), 64'(tbl[i].e0));
            chk($sformatf("vec%0d rd1", i), 64'(ReadData[63:32]), 64'(tbl[i].e1));
            chk($sformatf("vec%0d busy", i), 64'(ReadBusy), 64'(tbl[i].eb));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d cnt", i), 64'(busy_cnt), 64'(tbl[i].ec));
        end

        drive(1,0,0,0,0,0,0,0);
        mEdge();
        @(posedge clk);
        #1;

        for (int c = 0; c < 3000; c++) begin
            logic [4:0] wr, id;
            wr = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3))
                                             : 5'($urandom);
            id = ($urandom_range(0, 1) == 0) ? wr : 5'($urandom);
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1,
                  wr, $urandom, 5'($urandom),
                  ($urandom_range(0, 2) == 0) ? wr : 5'($urandom),
                  $urandom_range(0, 2) != 0, id);
            #2;
            chk("rnd rd0", 64'(ReadData[31:0]), 64'(mRead(ReadReg[4:0])));
            chk("rnd rd1", 64'(ReadData[63:32]), 64'(mRead(ReadReg[9:5])));
            chk("rnd busy", 64'(ReadBusy),
                64'({mBusyRd(ReadReg[9:5]), mBusyRd(ReadReg[4:0])}));
            mEdge();
            @(posedge clk);
            #1;
            chk("rnd cnt", 64'(busy_cnt), 64'(mCount()));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
